// File: rtl/ram_write_ctrl.sv
// Write-side controller for the 32x4 lab RAM: debounces two pushbuttons and
// issues single writes or a full fill sweep on the RAM write port.
module ram_write_ctrl #(
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              key_wr,
  input  logic              key_fill,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [7:0]        wr_count
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  logic [1:0] key_raw;
  logic [1:0] press;   // [0] = write event, [1] = fill event

  assign key_raw = {key_fill, key_wr};

  for (genvar g = 0; g < 2; g++) begin : gen_key
    logic             sync1, sync2, db, db_d, press_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        db      <= 1'b1;
        db_d    <= 1'b1;
        press_q <= 1'b0;
        cnt     <= '0;
      end else begin
        sync1   <= key_raw[g];
        sync2   <= sync1;
        db_d    <= db;
        press_q <= db_d & ~db;
        if (sync2 == db) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press[g] = press_q;
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              wr_en_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [7:0]        count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      wr_count <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      wr_en    <= wr_en_d;
      wr_addr  <= addr_d;
      wr_data  <= data_d;
      busy     <= busy_d;
      wr_count <= count_d;
    end
  end

  // Outputs are computed one state ahead so wr_en is high exactly while in WRITE/FILL.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    wr_en_d = 1'b0;
    busy_d  = 1'b0;
    addr_d  = wr_addr;
    data_d  = wr_data;
    count_d = wr_count;
    case (state_q)
      IDLE: begin
        if (press[1]) begin
          state_d = FILL;
          fill_d  = sw_data;
          addr_d  = '0;
          data_d  = sw_data;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
        end else if (press[0]) begin
          state_d = WRITE;
          addr_d  = sw_addr;
          data_d  = sw_data;
          wr_en_d = 1'b1;
          count_d = (wr_count == 8'hFF) ? wr_count : wr_count + 8'd1;
        end
      end
      WRITE: state_d = IDLE;
      FILL: begin
        if (wr_addr == '1) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          addr_d  = wr_addr + ADDR_W'(1);
          data_d  = fill_q;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Randomized bench for ram_write_ctrl against a window-based debounce and
// transaction-level write model.
module tb_ram_write_ctrl;

  localparam int D    = 4;
  localparam int NLOC = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;
  logic       key_wr, key_fill;
  logic       wr_en, busy;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] wr_count;

  ram_write_ctrl #(
    .ADDR_W(5),
    .DATA_W(4),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .sw_addr(sw_addr), .sw_data(sw_data),
    .key_wr(key_wr), .key_fill(key_fill), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a key's debounced level flips once the synchronized line
  // (key delayed two samples) has shown the other level for D samples in a row.
  typedef logic hist_t [D+2];
  hist_t      hw, hf;
  logic       db_w, db_f, fw1, fw2, ff1, ff2;
  int         k, free_from, fill_start, e_cnt;
  bit         in_fill;
  logic [3:0] fill_val, e_data;
  logic [4:0] e_addr;
  logic       e_en, e_busy;

  function automatic bit held_other(input hist_t h, input logic db);
    for (int j = 2; j < D + 2; j++)
      if (h[j] == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D + 2; i++) begin
      hw[i] = 1'b1;
      hf[i] = 1'b1;
    end
    db_w = 1; db_f = 1; fw1 = 0; fw2 = 0; ff1 = 0; ff2 = 0;
    k = -1; free_from = 0; in_fill = 0; fill_start = 0; fill_val = '0;
    e_en = 0; e_addr = '0; e_data = '0; e_busy = 0; e_cnt = 0;
  endtask

  task automatic model_edge(input logic kw, input logic kf, input logic [4:0] a, input logic [3:0] d);
    logic fall_w, fall_f;
    k++;
    for (int i = D + 1; i > 0; i--) begin
      hw[i] = hw[i-1];
      hf[i] = hf[i-1];
    end
    hw[0] = kw;
    hf[0] = kf;
    e_en = 0;
    if (in_fill) begin
      if (k - fill_start == NLOC) begin
        in_fill = 0; e_busy = 0; e_cnt = 0;
      end else begin
        e_en = 1; e_addr = 5'(k - fill_start); e_data = fill_val;
      end
    end
    if (k >= free_from) begin
      if (ff2) begin
        in_fill = 1; fill_start = k; fill_val = d; free_from = k + NLOC + 1;
        e_en = 1; e_addr = '0; e_data = d; e_busy = 1;
      end else if (fw2) begin
        free_from = k + 2;
        e_en = 1; e_addr = a; e_data = d;
        if (e_cnt < 255) e_cnt++;
      end
    end
    fall_w = 0;
    fall_f = 0;
    if (held_other(hw, db_w)) begin db_w = ~db_w; fall_w = ~db_w; end
    if (held_other(hf, db_f)) begin db_f = ~db_f; fall_f = ~db_f; end
    fw2 = fw1; fw1 = fall_w;
    ff2 = ff1; ff1 = fall_f;
  endtask

  int cyc = 0;
  int n_pulse = 0;
  int n_busy = 0;
  int first_en = -1;

  // Drive one edge's inputs, advance the model, then compare at the next negedge.
  task automatic cycle(input logic kw, input logic kf);
    int e;
    key_wr   = kw;
    key_fill = kf;
    model_edge(kw, kf, sw_addr, sw_data);
    @(negedge clk);
    e = cyc;
    cyc++;
    if (wr_en === 1'b1) begin
      n_pulse++;
      if (first_en < 0) first_en = e;
    end
    if (busy === 1'b1) n_busy++;
    check("wr_en", 32'(wr_en), 32'(e_en));
    check("wr_addr", 32'(wr_addr), 32'(e_addr));
    check("wr_data", 32'(wr_data), 32'(e_data));
    check("busy", 32'(busy), 32'(e_busy));
    check("wr_count", 32'(wr_count), 32'(e_cnt));
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    key_wr   = 1'b1;
    key_fill = 1'b1;
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic press(input bit use_wr, input bit use_fill, input int low, input int high);
    repeat (low)  cycle(use_wr ? 1'b0 : 1'b1, use_fill ? 1'b0 : 1'b1);
    repeat (high) cycle(1'b1, 1'b1);
  endtask

  initial begin
    int p0, b0, t0, rw, rf;
    bit found;
    logic kw, kf;
    reset = 1'b1; key_wr = 1'b1; key_fill = 1'b1; sw_addr = '0; sw_data = '0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Clean single write
    sw_addr = 5'h0A; sw_data = 4'h7;
    p0 = n_pulse; b0 = n_busy; first_en = -1; t0 = cyc;
    press(1, 0, 20, 15);
    check("clean_pulses", n_pulse - p0, 1);
    check("clean_latency", first_en - t0, 7);
    check("clean_count", 32'(wr_count), 1);
    check("clean_busy", n_busy - b0, 0);

    // Bounce rejection
    apply_reset();
    p0 = n_pulse;
    repeat (5) press(1, 0, 3, 2);
    repeat (10) cycle(1'b1, 1'b1);
    check("bounce_pulses", n_pulse - p0, 0);
    check("bounce_count", 32'(wr_count), 0);

    // Fill sweep, switches changing mid-sweep
    sw_data = 4'hC;
    p0 = n_pulse; b0 = n_busy;
    repeat (8) cycle(1'b1, 1'b0);
    repeat (45) begin
      sw_data = 4'($urandom);
      sw_addr = 5'($urandom);
      cycle(1'b1, 1'b1);
    end
    check("fill_pulses", n_pulse - p0, NLOC);
    check("fill_busy", n_busy - b0, NLOC);
    check("fill_count", 32'(wr_count), 0);

    // Simultaneous presses: fill only
    p0 = n_pulse;
    press(1, 1, 8, 45);
    check("both_pulses", n_pulse - p0, NLOC);

    // key_wr during sweep is dropped
    p0 = n_pulse;
    repeat (8) cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b1);
    repeat (40) cycle(1'b1, 1'b1);
    check("discard_pulses", n_pulse - p0, NLOC);

    // Reset mid-fill
    found = 0;
    repeat (8) cycle(1'b1, 1'b0);
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1'b1, 1'b1);
      if (wr_en === 1'b1 && wr_addr == 5'd10) found = 1;
    end
    check("reach_addr10", 32'(found), 1);
    apply_reset();
    p0 = n_pulse;
    repeat (100) cycle(1'b1, 1'b1);
    check("post_reset_quiet", n_pulse - p0, 0);

    // Long hold gives one write
    p0 = n_pulse;
    press(1, 0, 1000, 10);
    check("hold_pulses", n_pulse - p0, 1);

    // Saturation
    apply_reset();
    p0 = n_pulse;
    for (int i = 0; i < 300; i++) begin
      sw_addr = 5'($urandom);
      sw_data = 4'($urandom);
      press(1, 0, $urandom_range(6, 10), $urandom_range(6, 10));
    end
    check("sat_pulses", n_pulse - p0, 300);
    check("sat_count", 32'(wr_count), 255);

    // Random key chatter and switch changes
    kw = 1; kf = 1; rw = 5; rf = 9;
    repeat (3000) begin
      if (--rw <= 0) begin kw = ~kw; rw = $urandom_range(1, 12); end
      if (--rf <= 0) begin kf = ~kf; rf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(20, 60); end
      if ($urandom_range(0, 7) == 0) begin
        sw_addr = 5'($urandom);
        sw_data = 4'($urandom);
      end
      cycle(kw, kf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_write_ctrl.md
Name: ram_write_ctrl

Overview:
- Upstream write-side controller for the 32x4 lab RAM.
- Turns raw board pushbuttons and switches into clean, single-cycle RAM write transactions (wr_en/wr_addr/wr_data), which feed the RAM write port directly.
- Supports two operations:
  - Single write: one location from the switch settings.
  - Fill sweep: writes one value into every RAM location.
- Also provides busy and write-count status for display logic.

Parameters:
- ADDR_W, 5: RAM address width; the sweep covers 2^ADDR_W locations.
- DATA_W, 4: RAM data width.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a key change (20 ms at 50 MHz). Set to 4 in simulation.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset  input  1  asynchronous, active-low reset
- sw_addr  input  ADDR_W  target address from switches (asynchronous to clk)
- sw_data  input  DATA_W  write/fill data from switches (asynchronous to clk)
- key_wr  input  1  raw pushbutton, active-low (0 = pressed); requests a single write
- key_fill  input  1  raw pushbutton, active-low; requests a fill sweep
- wr_en  output  1  RAM write enable, registered
- wr_addr  output  ADDR_W  RAM write address, registered
- wr_data  output  DATA_W  RAM write data, registered
- busy  output  1  high while a fill sweep is in progress
- wr_count  output  8  number of single writes since the last fill or reset; saturates at 255

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, busy=0, wr_count=0.
  - Internal: state=IDLE; key synchronizers and debounced key states = 1 (released); debounce counters = 0.
  - Reset asserted mid-sweep aborts the sweep immediately; no write occurs after release until a new press.
- Synchronization:
  - Each key passes through a 2-flop synchronizer.
  - sw_addr/sw_data are captured only at the command-accept cycle; no synchronizer, since the switches are quasi-static.
- Debounce, per key:
  - Counter clears whenever the synchronized value equals the debounced state.
  - Otherwise the counter increments.
  - When it would reach DEBOUNCE_CYCLES, the debounced state takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: one-cycle pulse on the debounced 1->0 transition. Holding a key yields exactly one event; a release (0->1) produces none.
- State machine, IDLE / WRITE / FILL:
  - IDLE, fill event: latch fill value = sw_data, wr_addr=0, go to FILL, busy=1.
  - IDLE, write event (no fill event): latch wr_addr=sw_addr, wr_data=sw_data, go to WRITE.
  - WRITE: wr_en=1 for exactly one cycle; wr_count += 1 unless already 255; then IDLE.
  - FILL: wr_en=1 every cycle with wr_data = fill value. wr_addr starts at 0 and increments by 1 each cycle.
  - FILL end: after the write to address 2^ADDR_W-1, go to IDLE next cycle with wr_en=0, busy=0, wr_count=0.
  - Sweep length is exactly 2^ADDR_W consecutive wr_en cycles; busy is high for the same cycles.
- Simultaneous write and fill events in IDLE: fill wins; the write event is discarded.
- Events arriving in WRITE or FILL are discarded, not queued.
- Latency:
  - Clean press: key seen low at the synchronizer input on edge 0; event pulse at edge DEBOUNCE_CYCLES+2; first wr_en high on edge DEBOUNCE_CYCLES+3.
  - Every operation's latency is measured from that first wr_en edge.
- Outside WRITE/FILL: wr_en=0, and wr_addr/wr_data hold their last values.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean single write: reset, sw_addr=5'h0A, sw_data=4'h7, hold key_wr=0 for 20 cycles -> exactly one wr_en pulse, 7 cycles after first low sample, with wr_addr=0A and wr_data=7; wr_count=1; busy stays 0.
- Bounce rejection: key_wr low for 3 cycles, high for 2, repeated 5 times then high -> no wr_en; wr_count=0.
- Fill sweep: sw_data=4'hC, clean key_fill press -> 32 consecutive wr_en cycles, addr 0..31, data C; busy high for those same 32 cycles; wr_count=0 afterwards. Changing sw_data mid-sweep does not alter wr_data.
- Arbitration and discard: both keys pressed on the same cycle -> fill only. key_wr pressed during the sweep -> no extra write after the sweep ends.
- Reset mid-fill: assert reset at wr_addr=10 -> wr_en=0, busy=0, wr_addr=0 immediately. After release with keys idle, no writes for 100 cycles.
- Hold and saturation: key_wr held for 1000 cycles -> one write. 300 separate clean presses -> wr_count=255, and writes continue to occur.
